// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// Carries IR fields, ALU/memory status and every datapath control line.
interface multicycle_controller_if #(
  parameter int OP_W      = 6,
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 5
);
  logic [OP_W-1:0]      op;
  logic [FUNCT_W-1:0]   funct;
  logic                 zero;
  logic                 mem_ready;
  logic                 mem_req;
  logic                 iord;
  logic                 memwrite;
  logic                 irwrite;
  logic                 pcen;
  logic [1:0]           pcsrc;
  logic                 alusrca;
  logic [1:0]           alusrcb;
  logic [ALUCTRL_W-1:0] alucontrol;
  logic                 regwrite;
  logic [1:0]           regdst;
  logic [1:0]           wbsel;
  logic                 illegal;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, iord, memwrite, irwrite,
    output pcen, pcsrc, alusrca, alusrcb,
    output alucontrol, regwrite, regdst,
    output wbsel, illegal
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, iord, memwrite, irwrite,
    input  pcen, pcsrc, alusrca, alusrcb,
    input  alucontrol, regwrite, regdst,
    input  wbsel, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared-ALU multicycle MIPS datapath.
// MC_MEM_WAIT_EN: memory states stall until mem_ready is seen.
module multicycle_controller #(
  parameter int OP_W      = 6,
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 5
) (
  input  logic clk,
  input  logic reset,
  multicycle_controller_if.master bus
);
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_JR      = 4'd12;
  localparam logic [3:0] S_JAL     = 4'd13;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL  = 6'b000011;

  localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;
  localparam logic [FUNCT_W-1:0] F_JR  = 6'b001000;

  localparam logic [ALUCTRL_W-1:0] A_AND = 5'b00000;
  localparam logic [ALUCTRL_W-1:0] A_OR  = 5'b00001;
  localparam logic [ALUCTRL_W-1:0] A_ADD = 5'b00010;
  localparam logic [ALUCTRL_W-1:0] A_SUB = 5'b00110;
  localparam logic [ALUCTRL_W-1:0] A_SLT = 5'b00111;

  logic [3:0] state, next;
  logic mem_ok;
  logic is_r, is_mem, is_jr, is_ralu, is_br;
  logic mreq, mw, irw, pcw, br, ne, rw, ill;

`ifdef MC_MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  logic unused_ready;
  assign unused_ready = bus.mem_ready;
  assign mem_ok = 1'b1;
`endif

  assign is_r   = bus.op == OP_R;
  assign is_mem = bus.op == OP_LW || bus.op == OP_SW;
  assign is_jr  = is_r && bus.funct == F_JR;
  assign is_br  = bus.op == OP_BEQ || bus.op == OP_BNE;
  assign is_ralu = is_r && (bus.funct == F_ADD ||
                            bus.funct == F_SUB ||
                            bus.funct == F_AND ||
                            bus.funct == F_OR  ||
                            bus.funct == F_SLT);

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  // Next state and raw Moore control lines for the current state.
  always_comb begin
    next            = state;
    mreq            = 1'b0;
    mw              = 1'b0;
    irw             = 1'b0;
    pcw             = 1'b0;
    br              = 1'b0;
    ne              = 1'b0;
    rw              = 1'b0;
    ill             = 1'b0;
    bus.iord        = 1'b0;
    bus.pcsrc       = 2'b00;
    bus.alusrca     = 1'b0;
    bus.alusrcb     = 2'b00;
    bus.alucontrol  = A_ADD;
    bus.regdst      = 2'b00;
    bus.wbsel       = 2'b00;
    case (state)
      S_FETCH: begin
        mreq        = 1'b1;
        bus.alusrcb = 2'b01;
        if (mem_ok) begin
          irw  = 1'b1;
          pcw  = 1'b1;
          next = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.alusrcb = 2'b11;
        unique case (1'b1)
          is_mem:            next = S_MEMADR;
          is_jr:             next = S_JR;
          is_ralu:           next = S_EXECUTE;
          is_br:             next = S_BRANCH;
          bus.op == OP_ADDI: next = S_ADDIEX;
          bus.op == OP_J:    next = S_JUMP;
          bus.op == OP_JAL:  next = S_JAL;
          default: begin
            ill  = 1'b1;
            next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        next = bus.op == OP_SW ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mreq     = 1'b1;
        bus.iord = 1'b1;
        if (mem_ok) next = S_MEMWB;
      end
      S_MEMWB: begin
        rw        = 1'b1;
        bus.wbsel = 2'b01;
        next      = S_FETCH;
      end
      S_MEMWR: begin
        mreq     = 1'b1;
        bus.iord = 1'b1;
        if (mem_ok) begin
          mw   = 1'b1;
          next = S_FETCH;
        end
      end
      S_EXECUTE: begin
        bus.alusrca = 1'b1;
        case (bus.funct)
          F_SUB:   bus.alucontrol = A_SUB;
          F_AND:   bus.alucontrol = A_AND;
          F_OR:    bus.alucontrol = A_OR;
          F_SLT:   bus.alucontrol = A_SLT;
          default: bus.alucontrol = A_ADD;
        endcase
        next = S_ALUWB;
      end
      S_ALUWB: begin
        rw         = 1'b1;
        bus.regdst = 2'b01;
        next       = S_FETCH;
      end
      S_BRANCH: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = A_SUB;
        bus.pcsrc      = 2'b01;
        br             = 1'b1;
        ne             = bus.op == OP_BNE;
        next           = S_FETCH;
      end
      S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        next        = S_ADDIWB;
      end
      S_ADDIWB: begin
        rw   = 1'b1;
        next = S_FETCH;
      end
      S_JUMP: begin
        bus.pcsrc = 2'b10;
        pcw       = 1'b1;
        next      = S_FETCH;
      end
      S_JR: begin
        bus.pcsrc = 2'b11;
        pcw       = 1'b1;
        next      = S_FETCH;
      end
      S_JAL: begin
        bus.pcsrc  = 2'b10;
        pcw        = 1'b1;
        rw         = 1'b1;
        bus.regdst = 2'b10;
        bus.wbsel  = 2'b10;
        next       = S_FETCH;
      end
      default: next = S_FETCH;
    endcase
  end

  // Strobes are suppressed while reset is held so nothing is written.
  always_comb begin
    bus.mem_req  = mreq & ~reset;
    bus.memwrite = mw & ~reset;
    bus.irwrite  = irw & ~reset;
    bus.pcen     = (pcw | (br & (bus.zero ^ ne))) & ~reset;
    bus.regwrite = rw & ~reset;
    bus.illegal  = ill & ~reset;
  end
endmodule
